nemesis_sound_cmd_latch: RTL and testbench

- Sound-CPU end of the sound-command path. Accepts command bytes from the main 68000 write strobe (and, optionally, the debug command source) into a small FIFO.
- Raises the Z80 INT line, presents the head byte on the Z80 data-read port, and pops the byte when the Z80 read completes.
- Sits between the main-CPU address decoder and the Z80 sound subsystem (AY-7/AY-8/PROM channels driven downstream by Z80 firmware).

---
 rtl/nemesis_sound_pkg.sv | 16 +
 rtl/nemesis_sound_cmd_fifo.sv | 64 ++++++
 rtl/nemesis_sound_cmd_latch.sv | 126 ++++++++++++
 tb/tb_nemesis_sound_cmd_latch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nemesis_sound_pkg.sv
// Shared definitions for the sound-command latch: IRQ FSM encoding and
// well-known command byte values.
package nemesis_sound_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_WAIT_RD = 2'd2
  } irq_state_e;

  localparam logic [7:0] CMD_MUSIC_OFF    = 8'h00;
  localparam logic [7:0] CMD_SHOT         = 8'h01;
  localparam logic [7:0] CMD_CREDIT       = 8'h40;
  localparam logic [7:0] CMD_CORE_EXPLODE = 8'h81;

endpackage

// File: rtl/nemesis_sound_cmd_fifo.sv
// Command byte FIFO: storage, wrapping pointers, occupancy and a registered
// head byte that keeps the last popped value once the FIFO drains.
module nemesis_sound_cmd_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [7:0]            i_push_data,
  input  logic                  i_pop,
  output logic [7:0]            o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            head_q;
  logic                  push_ok, pop_ok;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LEVEL_FULL);

  // A push into a full FIFO still fits when the same cycle frees a slot.
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      head_q  <= 8'h00;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      // Only refresh while something is queued so the last byte sticks.
      if (!o_empty) head_q <= mem_q[rptr_q];
    end
  end

  assign o_head  = head_q;
  assign o_level = level_q;

endmodule

// File: rtl/nemesis_sound_cmd_latch.sv
// Sound-CPU command latch: strobe edge detect, FIFO, sticky overflow and Z80 IRQ
// handshake. Define NEMESIS_SOUND_DEBUG_EN to add the debug command source.
module nemesis_sound_cmd_latch
  import nemesis_sound_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_rd,
  input  logic                  i_irq_ack,
`ifdef NEMESIS_SOUND_DEBUG_EN
  input  logic                  i_dbg_trig,
  input  logic [7:0]            i_dbg_data,
`endif
  output logic [7:0]            o_rd_data,
  output logic                  o_irq_n,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow
);

  logic       wr_q, rd_q;
  logic       push_req, pop_req, pop_ok;
  logic       push;
  logic [7:0] push_data;
  logic       fifo_full, fifo_empty;
  logic       overflow_q, overflow_d;
  logic       nonempty_q;
  irq_state_e state_q, state_d;

  assign push_req = i_wr & ~wr_q;
  assign pop_req  = ~i_rd & rd_q;
  assign pop_ok   = pop_req & ~fifo_empty;

`ifdef NEMESIS_SOUND_DEBUG_EN
  logic       dbg_trig_q, dbg_req;
  logic       dbg_pend_q, dbg_pend_d;
  logic [7:0] dbg_data_q, dbg_data_d;

  assign dbg_req = i_dbg_trig & ~dbg_trig_q;

  // CPU writes win a collision; the debug byte waits one slot in pend.
  always_comb begin
    push       = push_req;
    push_data  = i_wr_data;
    dbg_pend_d = dbg_pend_q;
    dbg_data_d = dbg_data_q;
    if (push_req) begin
      if (dbg_req && !dbg_pend_q) begin
        dbg_pend_d = 1'b1;
        dbg_data_d = i_dbg_data;
      end
    end else if (dbg_pend_q) begin
      push       = 1'b1;
      push_data  = dbg_data_q;
      dbg_pend_d = 1'b0;
    end else if (dbg_req) begin
      push      = 1'b1;
      push_data = i_dbg_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dbg_trig_q <= 1'b0;
      dbg_pend_q <= 1'b0;
      dbg_data_q <= 8'h00;
    end else begin
      dbg_trig_q <= i_dbg_trig;
      dbg_pend_q <= dbg_pend_d;
      dbg_data_q <= dbg_data_d;
    end
  end
`else
  assign push      = push_req;
  assign push_data = i_wr_data;
`endif

  nemesis_sound_cmd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (pop_req),
    .o_head      (o_rd_data),
    .o_level     (o_level),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign overflow_d = overflow_q | (push & fifo_full & ~pop_req);

  // nonempty_q lags the level so INT only rises once the head byte is on the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:    if (nonempty_q && !fifo_empty) state_d = IRQ_ASSERT;
      IRQ_ASSERT:  if (pop_ok) state_d = IRQ_IDLE;
                   else if (i_irq_ack) state_d = IRQ_WAIT_RD;
      IRQ_WAIT_RD: if (pop_ok) state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      overflow_q <= 1'b0;
      nonempty_q <= 1'b0;
      state_q    <= IRQ_IDLE;
    end else begin
      wr_q       <= i_wr;
      rd_q       <= i_rd;
      overflow_q <= overflow_d;
      nonempty_q <= ~fifo_empty;
      state_q    <= state_d;
    end
  end

  assign o_irq_n    = (state_q != IRQ_ASSERT);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_nemesis_sound_cmd_latch.sv
// Bench for nemesis_sound_cmd_latch: directed command sequences, read data
// checked by a monitor against a queue of expected bytes.
module tb_nemesis_sound_cmd_latch;
  import nemesis_sound_pkg::*;

  localparam int DEPTH_LOG2 = 2;

  logic                clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_wr = 1'b0;
  logic [7:0]          i_wr_data = 8'h00;
  logic                i_rd = 1'b0;
  logic                i_irq_ack = 1'b0;
`ifdef NEMESIS_SOUND_DEBUG_EN
  logic                i_dbg_trig = 1'b0;
  logic [7:0]          i_dbg_data = 8'h00;
`endif
  logic [7:0]          o_rd_data;
  logic                o_irq_n;
  logic [DEPTH_LOG2:0] o_level;
  logic                o_overflow;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       rd_prev = 1'b0;

  always #5 clk = ~clk;

  nemesis_sound_cmd_latch #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .i_rd       (i_rd),
    .i_irq_ack  (i_irq_ack),
`ifdef NEMESIS_SOUND_DEBUG_EN
    .i_dbg_trig (i_dbg_trig),
    .i_dbg_data (i_dbg_data),
`endif
    .o_rd_data  (o_rd_data),
    .o_irq_n    (o_irq_n),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cmd(input logic [7:0] d, input bit accepted);
    i_wr      = 1'b1;
    i_wr_data = d;
    if (accepted) exp_q.push_back(d);
    tick();
    i_wr = 1'b0;
    tick();
    $display("write %02h accepted=%0d level=%0d", d, accepted, o_level);
  endtask

  task automatic read_cmd();
    i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
    tick();
    tick();
    $display("read done level=%0d rd_data=%02h", o_level, o_rd_data);
  endtask

  task automatic reset_pulse();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Monitor: a completed Z80 read (i_rd falling) must see the expected head byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_prev && !i_rd && i_rst_n && exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rd_data", 16'(o_rd_data), 16'(e));
        $display("pop observed %02h expected %02h", o_rd_data, e);
      end
      rd_prev = i_rd;
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_level", 16'(o_level), 16'd0);
    check("rst_rd_data", 16'(o_rd_data), 16'(CMD_MUSIC_OFF));
    check("rst_irq_n", 16'(o_irq_n), 16'd1);
    check("rst_overflow", 16'(o_overflow), 16'd0);
    i_rst_n = 1'b1;
    tick();

    // Single command with acknowledged interrupt
    i_wr      = 1'b1;
    i_wr_data = CMD_CREDIT;
    exp_q.push_back(CMD_CREDIT);
    tick();
    check("t1_level_push", 16'(o_level), 16'd1);
    check("t1_rd_before", 16'(o_rd_data), 16'h00);
    i_wr = 1'b0;
    tick();
    check("t1_rd_after1", 16'(o_rd_data), 16'h40);
    check("t1_irq_after1", 16'(o_irq_n), 16'd1);
    tick();
    check("t1_irq_after2", 16'(o_irq_n), 16'd0);
    i_irq_ack = 1'b1;
    tick();
    i_irq_ack = 1'b0;
    check("t1_irq_ack", 16'(o_irq_n), 16'd1);
    read_cmd();
    check("t1_level_end", 16'(o_level), 16'd0);
    check("t1_rd_hold", 16'(o_rd_data), 16'h40);
    check("t1_irq_end", 16'(o_irq_n), 16'd1);

    // Fill to full, one dropped push
    write_cmd(CMD_SHOT, 1'b1);
    write_cmd(8'h02, 1'b1);
    write_cmd(8'h03, 1'b1);
    write_cmd(8'h1A, 1'b1);
    check("t2_ovf_before", 16'(o_overflow), 16'd0);
    write_cmd(CMD_CORE_EXPLODE, 1'b0);
    check("t2_level_full", 16'(o_level), 16'd4);
    check("t2_overflow", 16'(o_overflow), 16'd1);
    for (int i = 0; i < 4; i++) read_cmd();
    check("t2_level_empty", 16'(o_level), 16'd0);
    check("t2_ovf_sticky", 16'(o_overflow), 16'd1);
    read_cmd();
    check("t2_empty_pop_level", 16'(o_level), 16'd0);
    check("t2_empty_pop_rd", 16'(o_rd_data), 16'h1A);
    reset_pulse();
    check("t2_ovf_cleared", 16'(o_overflow), 16'd0);

    // Full FIFO, simultaneous push and pop
    write_cmd(8'hA0, 1'b1);
    write_cmd(8'hA1, 1'b1);
    write_cmd(8'hA2, 1'b1);
    write_cmd(8'hA3, 1'b1);
    check("t3_level_full", 16'(o_level), 16'd4);
    i_rd = 1'b1;
    tick();
    i_rd      = 1'b0;
    i_wr      = 1'b1;
    i_wr_data = 8'h12;
    exp_q.push_back(8'h12);
    tick();
    i_wr = 1'b0;
    check("t3_level_same", 16'(o_level), 16'd4);
    check("t3_no_overflow", 16'(o_overflow), 16'd0);
    tick();
    for (int i = 0; i < 4; i++) read_cmd();
    check("t3_level_empty", 16'(o_level), 16'd0);
    check("t3_last_byte", 16'(o_rd_data), 16'h12);

    // Interrupt gap between two queued commands
    reset_pulse();
    write_cmd(8'h55, 1'b1);
    write_cmd(8'h66, 1'b1);
    check("t4_irq_low", 16'(o_irq_n), 16'd0);
    i_irq_ack = 1'b1;
    tick();
    i_irq_ack = 1'b0;
    check("t4_irq_ack", 16'(o_irq_n), 16'd1);
    i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
    tick();
    check("t4_gap_irq", 16'(o_irq_n), 16'd1);
    check("t4_gap_rd", 16'(o_rd_data), 16'h55);
    tick();
    check("t4_irq_again", 16'(o_irq_n), 16'd0);
    check("t4_second_rd", 16'(o_rd_data), 16'h66);
    read_cmd();
    check("t4_irq_done", 16'(o_irq_n), 16'd1);

    // Asynchronous reset between clock edges with three bytes queued
    write_cmd(8'hC1, 1'b0);
    write_cmd(8'hC2, 1'b0);
    write_cmd(8'hC3, 1'b0);
    check("t5_level_pre", 16'(o_level), 16'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_irq_n", 16'(o_irq_n), 16'd1);
    check("t5_level", 16'(o_level), 16'd0);
    check("t5_rd_data", 16'(o_rd_data), 16'h00);
    tick();
    i_rst_n = 1'b1;
    tick();

`ifdef NEMESIS_SOUND_DEBUG_EN
    // CPU and debug edges in the same cycle: CPU byte first
    i_wr       = 1'b1;
    i_wr_data  = 8'h4B;
    i_dbg_trig = 1'b1;
    i_dbg_data = 8'h49;
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h49);
    tick();
    i_wr       = 1'b0;
    i_dbg_trig = 1'b0;
    tick();
    check("t6_dbg_level", 16'(o_level), 16'd2);
    read_cmd();
    read_cmd();
    check("t6_dbg_empty", 16'(o_level), 16'd0);
`endif

    tick();
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
